// File: rtl/cache_assoc_control_if.sv
// Handshake bundle between the associative cache controller, its requester,
// the backing memory and the tag/data/valid/dirty datapath.
interface cache_assoc_control_if #(
  parameter int BYTE_NUM = 8,
  parameter int WAYS     = 4,
  parameter int SETS     = 16
);
  localparam int SET_W = $clog2(SETS);

  logic                mem_ack;
  logic                mem_rd_en;
  logic                mem_wr_en;
  logic [BYTE_NUM-1:0] mem_sel;
  logic                ctrl_rd_en;
  logic                ctrl_wr_en;
  logic                ctrl_flush;
  logic                ctrl_ack;
  logic [WAYS-1:0]     hit_way;
  logic [WAYS-1:0]     valid_way;
  logic [WAYS-1:0]     dirty_way;
  logic                ctrl_wr_en_d;
  logic [SET_W-1:0]    set_index_d;
  logic                sample_ctrl_inputs;
  logic                flush_active;
  logic [SET_W-1:0]    flush_set;
  logic [WAYS-1:0]     way_sel;
  logic                set_valid, set_tag, set_data, set_dirty;
  logic                clear_dirty, clear_valid;
  logic                wb_tag_sel;

  // master: requester + memory + datapath side; slave: the controller
  modport master (
    output mem_ack, ctrl_rd_en, ctrl_wr_en, ctrl_flush,
           hit_way, valid_way, dirty_way, ctrl_wr_en_d, set_index_d,
    input  mem_rd_en, mem_wr_en, mem_sel, ctrl_ack, sample_ctrl_inputs,
           flush_active, flush_set, way_sel, set_valid, set_tag, set_data,
           set_dirty, clear_dirty, clear_valid, wb_tag_sel
  );

  modport slave (
    input  mem_ack, ctrl_rd_en, ctrl_wr_en, ctrl_flush,
           hit_way, valid_way, dirty_way, ctrl_wr_en_d, set_index_d,
    output mem_rd_en, mem_wr_en, mem_sel, ctrl_ack, sample_ctrl_inputs,
           flush_active, flush_set, way_sel, set_valid, set_tag, set_data,
           set_dirty, clear_dirty, clear_valid, wb_tag_sel
  );
endinterface

// File: rtl/cache_assoc_control.sv
// Control FSM for an N-way set-associative write-back/write-allocate cache with
// round-robin victim choice per set and a full-cache flush walk.
module cache_assoc_control #(
  parameter int BYTE_NUM         = 8,
  parameter int WAYS             = 4,
  parameter int SETS             = 16,
  parameter int FLUSH_INVALIDATE = 0
) (
  input logic                  clock,
  input logic                  reset,
  cache_assoc_control_if.slave bus
);
  localparam int WAY_W = $clog2(WAYS);
  localparam int SET_W = $clog2(SETS);

  typedef enum logic [2:0] {
    S_IDLE, S_CMP, S_WB, S_ALLOC, S_FCHK, S_FWB, S_FDONE
  } state_t;

  state_t                      r_state;
  logic [WAY_W-1:0]            r_victim;
  logic                        r_all_valid;
  logic [SETS-1:0][WAY_W-1:0]  r_rr;
  logic [SET_W-1:0]            r_fset;
  logic [WAY_W-1:0]            r_fway;
  logic                        r_mem_rd, r_mem_wr, r_wb_sel, r_flush_active;

  logic                        w_hit, w_has_free, w_vict_dirty, w_fdirty, w_last;
  logic [WAY_W-1:0]            w_free, w_victim;
  logic [WAYS-1:0]             w_fway_oh, w_vict_oh;
  logic [SET_W-1:0]            w_fset_nxt;

  assign w_hit        = |bus.hit_way;
  assign w_fway_oh    = WAYS'(1) << r_fway;
  assign w_vict_oh    = WAYS'(1) << r_victim;
  assign w_fdirty     = bus.valid_way[r_fway] & bus.dirty_way[r_fway];
  assign w_last       = (r_fset == SET_W'(SETS-1)) && (r_fway == WAY_W'(WAYS-1));
  assign w_fset_nxt   = (r_fway == WAY_W'(WAYS-1)) ? r_fset + 1'b1 : r_fset;
  // A free way is never dirty, so only a full set can force a write-back
  assign w_vict_dirty = !w_has_free && bus.dirty_way[w_victim];

  always_comb begin
    w_free     = '0;
    w_has_free = 1'b0;
    for (int i = WAYS-1; i >= 0; i--) begin
      if (!bus.valid_way[i]) begin
        w_free     = WAY_W'(i);
        w_has_free = 1'b1;
      end
    end
    w_victim = w_has_free ? w_free : r_rr[bus.set_index_d];
  end

  assign bus.mem_rd_en    = r_mem_rd;
  assign bus.mem_wr_en    = r_mem_wr;
  assign bus.wb_tag_sel   = r_wb_sel;
  assign bus.mem_sel      = '1;
  assign bus.flush_active = r_flush_active;
  assign bus.flush_set    = r_fset;

  // Array strobes react to same-cycle array reads and mem_ack
  always_comb begin
    bus.sample_ctrl_inputs = 1'b0;
    bus.ctrl_ack           = 1'b0;
    bus.set_valid          = 1'b0;
    bus.set_tag            = 1'b0;
    bus.set_data           = 1'b0;
    bus.set_dirty          = 1'b0;
    bus.clear_dirty        = 1'b0;
    bus.clear_valid        = 1'b0;
    bus.way_sel            = (r_state == S_FCHK || r_state == S_FWB) ? w_fway_oh : w_vict_oh;
    case (r_state)
      S_IDLE:  bus.sample_ctrl_inputs = !bus.ctrl_flush && (bus.ctrl_rd_en || bus.ctrl_wr_en);
      S_CMP: begin
        bus.way_sel = bus.hit_way;
        if (w_hit) begin
          bus.set_valid = 1'b1;
          bus.set_tag   = 1'b1;
          bus.set_data  = bus.ctrl_wr_en_d;
          bus.set_dirty = bus.ctrl_wr_en_d;
          bus.ctrl_ack  = 1'b1;
        end
      end
      S_ALLOC: if (bus.mem_ack) begin
        bus.set_valid = 1'b1;
        bus.set_tag   = 1'b1;
        bus.set_data  = 1'b1;
      end
      S_FCHK:  bus.clear_valid = !w_fdirty && (FLUSH_INVALIDATE != 0);
      S_FWB: if (bus.mem_ack) begin
        bus.clear_dirty = 1'b1;
        bus.clear_valid = (FLUSH_INVALIDATE != 0);
      end
      S_FDONE: bus.ctrl_ack = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_victim       <= '0;
      r_all_valid    <= 1'b0;
      r_rr           <= '0;
      r_fset         <= '0;
      r_fway         <= '0;
      r_mem_rd       <= 1'b0;
      r_mem_wr       <= 1'b0;
      r_wb_sel       <= 1'b0;
      r_flush_active <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:
          if (bus.ctrl_flush) begin
            r_fset         <= '0;
            r_fway         <= '0;
            r_flush_active <= 1'b1;
            r_state        <= S_FCHK;
          end else if (bus.ctrl_rd_en || bus.ctrl_wr_en) begin
            r_state <= S_CMP;
          end
        S_CMP:
          if (w_hit) begin
            r_state <= S_IDLE;
          end else begin
            r_victim    <= w_victim;
            r_all_valid <= !w_has_free;
            if (w_vict_dirty) begin
              r_mem_wr <= 1'b1;
              r_wb_sel <= 1'b1;
              r_state  <= S_WB;
            end else begin
              r_mem_rd <= 1'b1;
              r_state  <= S_ALLOC;
            end
          end
        S_WB:
          if (bus.mem_ack) begin
            r_mem_wr <= 1'b0;
            r_wb_sel <= 1'b0;
            r_mem_rd <= 1'b1;
            r_state  <= S_ALLOC;
          end
        S_ALLOC:
          if (bus.mem_ack) begin
            r_mem_rd <= 1'b0;
            if (r_all_valid)
              r_rr[bus.set_index_d] <= r_rr[bus.set_index_d] + 1'b1;
            r_state <= S_CMP;
          end
        S_FCHK:
          if (w_fdirty) begin
            r_mem_wr <= 1'b1;
            r_wb_sel <= 1'b1;
            r_state  <= S_FWB;
          end else begin
            r_fway         <= r_fway + 1'b1;
            r_fset         <= w_fset_nxt;
            r_flush_active <= !w_last;
            r_state        <= w_last ? S_FDONE : S_FCHK;
          end
        S_FWB:
          if (bus.mem_ack) begin
            r_mem_wr       <= 1'b0;
            r_wb_sel       <= 1'b0;
            r_fway         <= r_fway + 1'b1;
            r_fset         <= w_fset_nxt;
            r_flush_active <= !w_last;
            r_state        <= w_last ? S_FDONE : S_FCHK;
          end
        S_FDONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_assoc_control.sv
// Directed bench for cache_assoc_control: the bench plays requester, memory and
// datapath array reads cycle by cycle.
module tb_cache_assoc_control;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_pass = 0;
  int   n_tot  = 0;

  cache_assoc_control_if #(.BYTE_NUM(8), .WAYS(4), .SETS(16)) bus ();

  cache_assoc_control #(.BYTE_NUM(8), .WAYS(4), .SETS(16), .FLUSH_INVALIDATE(1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_in();
    bus.mem_ack      = 1'b0;
    bus.ctrl_rd_en   = 1'b0;
    bus.ctrl_wr_en   = 1'b0;
    bus.ctrl_flush   = 1'b0;
    bus.hit_way      = '0;
    bus.valid_way    = '0;
    bus.dirty_way    = '0;
    bus.ctrl_wr_en_d = 1'b0;
    bus.set_index_d  = '0;
  endtask

  task automatic test_reset();
    clr_in();
    reset = 1'b1;
    #2;
    n_tot++; if ({bus.mem_rd_en, bus.mem_wr_en, bus.ctrl_ack, bus.flush_active} !== 4'b0000)
      $display("FAIL reset_outs got %b exp 0000", {bus.mem_rd_en, bus.mem_wr_en, bus.ctrl_ack, bus.flush_active}); else n_pass++;
    n_tot++; if (bus.mem_sel !== 8'hFF) $display("FAIL reset_mem_sel got %h exp ff", bus.mem_sel); else n_pass++;
    n_tot++; if ({bus.set_valid, bus.set_tag, bus.set_data, bus.set_dirty, bus.clear_dirty, bus.clear_valid} !== 6'b0)
      $display("FAIL reset_strobes got %b exp 000000", {bus.set_valid, bus.set_tag, bus.set_data, bus.set_dirty, bus.clear_dirty, bus.clear_valid}); else n_pass++;
    n_tot++; if (bus.flush_set !== 4'd0) $display("FAIL reset_flush_set got %0d exp 0", bus.flush_set); else n_pass++;
    @(negedge clock);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_read_miss();
    bus.set_index_d = 4'd3;
    bus.ctrl_rd_en  = 1'b1;
    #1;
    n_tot++; if (bus.sample_ctrl_inputs !== 1'b1) $display("FAIL rd_sample got %b exp 1", bus.sample_ctrl_inputs); else n_pass++;
    tick();
    n_tot++; if ({bus.ctrl_ack, bus.set_valid} !== 2'b00) $display("FAIL rd_cmp_miss got %b exp 00", {bus.ctrl_ack, bus.set_valid}); else n_pass++;
    tick();
    n_tot++; if ({bus.mem_rd_en, bus.mem_wr_en, bus.way_sel} !== 6'b10_0001)
      $display("FAIL rd_alloc got %b exp 100001", {bus.mem_rd_en, bus.mem_wr_en, bus.way_sel}); else n_pass++;
    tick();
    n_tot++; if (bus.mem_rd_en !== 1'b1) $display("FAIL rd_hold got %b exp 1", bus.mem_rd_en); else n_pass++;
    bus.mem_ack = 1'b1;
    #1;
    n_tot++; if ({bus.set_valid, bus.set_tag, bus.set_data, bus.set_dirty} !== 4'b1110)
      $display("FAIL rd_fill_strobes got %b exp 1110", {bus.set_valid, bus.set_tag, bus.set_data, bus.set_dirty}); else n_pass++;
    tick();
    bus.mem_ack   = 1'b0;
    bus.hit_way   = 4'b0001;
    bus.valid_way = 4'b0001;
    #1;
    n_tot++; if ({bus.ctrl_ack, bus.set_data, bus.set_dirty, bus.mem_rd_en} !== 4'b1000)
      $display("FAIL rd_hit_ack got %b exp 1000", {bus.ctrl_ack, bus.set_data, bus.set_dirty, bus.mem_rd_en}); else n_pass++;
    bus.ctrl_rd_en = 1'b0;
    tick();
    n_tot++; if (bus.ctrl_ack !== 1'b0) $display("FAIL rd_idle_ack got %b exp 0", bus.ctrl_ack); else n_pass++;
    clr_in();
  endtask

  task automatic test_lowest_free();
    bus.set_index_d = 4'd3;
    bus.ctrl_rd_en  = 1'b1;
    bus.valid_way   = 4'b0101;
    tick();
    tick();
    n_tot++; if (bus.way_sel !== 4'b0010) $display("FAIL free_victim got %b exp 0010", bus.way_sel); else n_pass++;
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    bus.hit_way = 4'b0010;
    bus.ctrl_rd_en = 1'b0;
    tick();
    clr_in();
  endtask

  task automatic test_rr_victim();
    int       sets[6];
    logic [3:0] expw[6];
    sets = '{3, 5, 5, 5, 5, 5};
    expw = '{4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int k = 0; k < 6; k++) begin
      bus.set_index_d = 4'(sets[k]);
      bus.valid_way   = 4'hF;
      bus.ctrl_rd_en  = 1'b1;
      tick();
      tick();
      n_tot++; if ({bus.mem_rd_en, bus.way_sel} !== {1'b1, expw[k]})
        $display("FAIL rr_victim_%0d got %b exp %b", k, {bus.mem_rd_en, bus.way_sel}, {1'b1, expw[k]}); else n_pass++;
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      bus.hit_way = expw[k];
      #1;
      n_tot++; if (bus.ctrl_ack !== 1'b1) $display("FAIL rr_ack_%0d got %b exp 1", k, bus.ctrl_ack); else n_pass++;
      bus.ctrl_rd_en = 1'b0;
      tick();
      bus.hit_way = '0;
    end
    clr_in();
  endtask

  task automatic test_write_hit();
    bus.set_index_d = 4'd5;
    bus.valid_way   = 4'hF;
    bus.ctrl_wr_en  = 1'b1;
    bus.ctrl_rd_en  = 1'b1;
    #1;
    n_tot++; if (bus.sample_ctrl_inputs !== 1'b1) $display("FAIL wr_sample got %b exp 1", bus.sample_ctrl_inputs); else n_pass++;
    tick();
    bus.hit_way      = 4'b0100;
    bus.ctrl_wr_en_d = 1'b1;
    #1;
    n_tot++; if ({bus.set_valid, bus.set_tag, bus.set_data, bus.set_dirty, bus.way_sel} !== 8'b1111_0100)
      $display("FAIL wr_hit_strobes got %b exp 11110100", {bus.set_valid, bus.set_tag, bus.set_data, bus.set_dirty, bus.way_sel}); else n_pass++;
    n_tot++; if ({bus.ctrl_ack, bus.mem_rd_en, bus.mem_wr_en} !== 3'b100)
      $display("FAIL wr_hit_ack got %b exp 100", {bus.ctrl_ack, bus.mem_rd_en, bus.mem_wr_en}); else n_pass++;
    bus.ctrl_wr_en = 1'b0;
    bus.ctrl_rd_en = 1'b0;
    tick();
    n_tot++; if (bus.ctrl_ack !== 1'b0) $display("FAIL wr_after_ack got %b exp 0", bus.ctrl_ack); else n_pass++;
    clr_in();
  endtask

  task automatic test_dirty_wb();
    bus.set_index_d = 4'd7;
    bus.valid_way   = 4'hF;
    bus.dirty_way   = 4'hF;
    bus.ctrl_wr_en  = 1'b1;
    tick();
    bus.ctrl_wr_en_d = 1'b1;
    tick();
    n_tot++; if ({bus.mem_wr_en, bus.wb_tag_sel, bus.mem_rd_en, bus.way_sel} !== 7'b110_0001)
      $display("FAIL wb_enter got %b exp 1100001", {bus.mem_wr_en, bus.wb_tag_sel, bus.mem_rd_en, bus.way_sel}); else n_pass++;
    tick();
    tick();
    n_tot++; if ({bus.mem_wr_en, bus.wb_tag_sel} !== 2'b11) $display("FAIL wb_hold got %b exp 11", {bus.mem_wr_en, bus.wb_tag_sel}); else n_pass++;
    bus.mem_ack = 1'b1;
    #1;
    n_tot++; if ({bus.set_valid, bus.set_dirty, bus.clear_dirty} !== 3'b000)
      $display("FAIL wb_ack_strobes got %b exp 000", {bus.set_valid, bus.set_dirty, bus.clear_dirty}); else n_pass++;
    tick();
    bus.mem_ack = 1'b0;
    #1;
    n_tot++; if ({bus.mem_rd_en, bus.mem_wr_en, bus.wb_tag_sel, bus.way_sel} !== 7'b100_0001)
      $display("FAIL wb_alloc got %b exp 1000001", {bus.mem_rd_en, bus.mem_wr_en, bus.wb_tag_sel, bus.way_sel}); else n_pass++;
    bus.mem_ack = 1'b1;
    #1;
    n_tot++; if ({bus.set_data, bus.set_dirty} !== 2'b10) $display("FAIL wb_fill_clean got %b exp 10", {bus.set_data, bus.set_dirty}); else n_pass++;
    tick();
    bus.mem_ack = 1'b0;
    bus.hit_way = 4'b0001;
    #1;
    n_tot++; if ({bus.ctrl_ack, bus.set_data, bus.set_dirty} !== 3'b111)
      $display("FAIL wb_write_done got %b exp 111", {bus.ctrl_ack, bus.set_data, bus.set_dirty}); else n_pass++;
    bus.ctrl_wr_en = 1'b0;
    tick();
    clr_in();
  endtask

  task automatic test_flush();
    int cyc = 0, bursts = 0, cd = 0, cv = 0, wcnt = 0, wb_bad = 0;
    int cd_set[2];
    logic [3:0] cd_way[2];
    logic done = 1'b0, fa_at_ack = 1'b1;
    cd_set = '{-1, -1};
    cd_way = '{4'h0, 4'h0};
    bus.ctrl_flush = 1'b1;
    #1;
    n_tot++; if (bus.sample_ctrl_inputs !== 1'b0) $display("FAIL fl_no_sample got %b exp 0", bus.sample_ctrl_inputs); else n_pass++;
    tick();
    bus.ctrl_flush = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      bus.valid_way = 4'hF;
      bus.dirty_way = (bus.flush_set == 4'd1) ? 4'b1000 : (bus.flush_set == 4'd9) ? 4'b0001 : 4'b0000;
      bus.mem_ack   = bus.mem_wr_en && (wcnt == 1);
      #1;
      cyc++;
      if (bus.mem_wr_en) begin
        if (wcnt == 0) bursts++;
        wcnt++;
        if (!bus.wb_tag_sel) wb_bad++;
      end
      if (bus.mem_ack) wcnt = 0;
      if (bus.clear_valid) cv++;
      if (bus.clear_dirty) begin
        if (cd < 2) begin cd_set[cd] = int'(bus.flush_set); cd_way[cd] = bus.way_sel; end
        cd++;
      end
      if (bus.ctrl_ack) begin done = 1'b1; fa_at_ack = bus.flush_active; end
      tick();
    end
    bus.mem_ack = 1'b0;
    n_tot++; if (!done) $display("FAIL fl_timeout got no ack exp ack within 200 cycles"); else n_pass++;
    n_tot++; if (cyc != 69) $display("FAIL fl_cycles got %0d exp 69", cyc); else n_pass++;
    n_tot++; if (bursts != 2) $display("FAIL fl_bursts got %0d exp 2", bursts); else n_pass++;
    n_tot++; if (cv != 64) $display("FAIL fl_clear_valid got %0d exp 64", cv); else n_pass++;
    n_tot++; if (cd != 2) $display("FAIL fl_clear_dirty got %0d exp 2", cd); else n_pass++;
    n_tot++; if (wb_bad != 0) $display("FAIL fl_wb_tag_sel got %0d low cycles exp 0", wb_bad); else n_pass++;
    n_tot++; if (cd_set[0] != 1 || cd_way[0] !== 4'b1000)
      $display("FAIL fl_cd0 got set %0d way %b exp set 1 way 1000", cd_set[0], cd_way[0]); else n_pass++;
    n_tot++; if (cd_set[1] != 9 || cd_way[1] !== 4'b0001)
      $display("FAIL fl_cd1 got set %0d way %b exp set 9 way 0001", cd_set[1], cd_way[1]); else n_pass++;
    n_tot++; if (fa_at_ack !== 1'b0) $display("FAIL fl_active_at_ack got %b exp 0", fa_at_ack); else n_pass++;
    n_tot++; if ({bus.ctrl_ack, bus.flush_active} !== 2'b00) $display("FAIL fl_after got %b exp 00", {bus.ctrl_ack, bus.flush_active}); else n_pass++;
    clr_in();
  endtask

  task automatic test_reset_mid_alloc();
    bus.set_index_d = 4'd2;
    bus.ctrl_rd_en  = 1'b1;
    tick();
    tick();
    n_tot++; if (bus.mem_rd_en !== 1'b1) $display("FAIL rst_pre got %b exp 1", bus.mem_rd_en); else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    n_tot++; if (bus.mem_rd_en !== 1'b0) $display("FAIL rst_async_rd got %b exp 0", bus.mem_rd_en); else n_pass++;
    bus.ctrl_flush = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_tot++; if (bus.sample_ctrl_inputs !== 1'b0) $display("FAIL rst_flush_prio got %b exp 0", bus.sample_ctrl_inputs); else n_pass++;
    tick();
    n_tot++; if ({bus.flush_active, bus.flush_set, bus.way_sel, bus.mem_rd_en} !== 10'b1_0000_0001_0)
      $display("FAIL rst_flush_taken got %b exp 1000000010", {bus.flush_active, bus.flush_set, bus.way_sel, bus.mem_rd_en}); else n_pass++;
    clr_in();
    reset = 1'b1;
    #3;
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_lowest_free();
    test_rr_victim();
    test_write_hit();
    test_dirty_wb();
    test_flush();
    test_reset_mid_alloc();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
